fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control FSM and the IF/ID pipeline register.
// Optional macro FETCH_ALIGN_CHECK_EN word-aligns redirect targets and pulses misalign_err.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        halted,
    output logic        misalign_err
);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    // Every state accepts a redirect, so the pulse needs no state qualification.
    assign misalign_d      = redirect && (redirect_pc[1:0] != 2'b00);
    assign misalign_err    = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign redirect_target = redirect_pc;
    assign misalign_err    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = 32'h0;
        if_pc_plus4_d = 32'h0;
        if_instr_d    = NOP_INSTR;
        if_valid_d    = 1'b0;

        case (state_q)
            BOOT: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (stall) begin
                    if_pc_d       = if_pc_q;
                    if_pc_plus4_d = if_pc_plus4_q;
                    if_instr_d    = if_instr_q;
                    if_valid_d    = if_valid_q;
                end else if (flush) begin
                    pc_d = pc_plus4;
                end else begin
                    pc_d          = pc_plus4;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_plus4;
                    if_instr_d    = imem_rdata;
                    if_valid_d    = 1'b1;
                    if (imem_rdata == ECALL_INSTR) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_instr_q    <= NOP_INSTR;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the driver queues the expected post-edge view, the monitor pops and compares.
module tb_fetch_stage;

    localparam logic [31:0] INSTR = 32'h0010_0093;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        vld;
        logic        halt;
        logic        mis;
    } view_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] ecall_addr;

    int checks   = 0;
    int failures = 0;

    view_t sb_q[$];
    string name_q[$];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .halted      (halted),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr == ecall_addr) ? ECALL : INSTR;

    function automatic view_t actual_view();
        view_t v;
        v.addr  = imem_addr;
        v.pc    = if_pc;
        v.pc4   = if_pc_plus4;
        v.instr = if_instr;
        v.vld   = if_valid;
        v.halt  = halted;
        v.mis   = misalign_err;
        return v;
    endfunction

    task automatic compare(input string name, input view_t exp);
        view_t act;
        act = actual_view();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got addr=%h pc=%h pc4=%h instr=%h vld=%b halt=%b mis=%b, want addr=%h pc=%h pc4=%h instr=%h vld=%b halt=%b mis=%b",
                     name, act.addr, act.pc, act.pc4, act.instr, act.vld, act.halt, act.mis,
                     exp.addr, exp.pc, exp.pc4, exp.instr, exp.vld, exp.halt, exp.mis);
        end
    endtask

    // Monitor: one expected view per clock edge while the queue holds entries.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                compare(name_q.pop_front(), sb_q.pop_front());
            end
        end
    end

    // Called at a negedge: drive inputs, queue the view expected after the next rising edge.
    task automatic step(input string name, input logic s, input logic f, input logic r,
                        input logic [31:0] rpc, input logic [31:0] e_addr, input logic [31:0] e_pc,
                        input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_vld,
                        input logic e_halt, input logic e_mis);
        view_t e;
        stall       = s;
        flush       = f;
        redirect    = r;
        redirect_pc = rpc;
        e = '{addr: e_addr, pc: e_pc, pc4: e_pc4, instr: e_instr, vld: e_vld, halt: e_halt, mis: e_mis};
        sb_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        view_t rst_view;
        rst_view    = '{addr: 32'h0, pc: 32'h0, pc4: 32'h0, instr: NOP, vld: 1'b0, halt: 1'b0, mis: 1'b0};
        ecall_addr  = 32'h20;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        rst_n       = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        compare("reset_async", rst_view);
        repeat (2) @(posedge clk);
        #1;
        compare("reset_held", rst_view);
        @(negedge clk);
        rst_n = 1'b1;

        //    name            s     f     r     rpc           addr          pc            pc4           instr  v     h     m
        step("boot",         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("first_fetch",  1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        INSTR, 1'b1, 1'b0, 1'b0);
        step("fetch_8",      1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        32'h8,        INSTR, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b1, 1'b0, 1'b0, 32'h0,      32'h8,        32'h4,        32'h8,        INSTR, 1'b1, 1'b0, 1'b0);
        end
        step("stall_resume", 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        INSTR, 1'b1, 1'b0, 1'b0);
        step("stall_over_fl",1'b1, 1'b1, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        INSTR, 1'b1, 1'b0, 1'b0);
        step("flush",        1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("after_flush",  1'b0, 1'b0, 1'b0, 32'h0,        32'h14,       32'h10,       32'h14,       INSTR, 1'b1, 1'b0, 1'b0);
        step("redir_stall",  1'b1, 1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("after_redir",  1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       INSTR, 1'b1, 1'b0, 1'b0);
        step("redir_20",     1'b0, 1'b1, 1'b1, 32'h20,       32'h20,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("ecall",        1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'h20,       32'h24,       ECALL, 1'b1, 1'b1, 1'b0);
        step("halt_idle",    1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'h0,        32'h0,        NOP,   1'b0, 1'b1, 1'b0);
        step("halt_ign_sf",  1'b1, 1'b1, 1'b0, 32'h0,        32'h24,       32'h0,        32'h0,        NOP,   1'b0, 1'b1, 1'b0);
        step("halt_redir",   1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("post_halt",    1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        INSTR, 1'b1, 1'b0, 1'b0);
        step("redir_top",    1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("wrap",         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC,32'h0,        INSTR, 1'b1, 1'b0, 1'b0);
        step("after_wrap",   1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        INSTR, 1'b1, 1'b0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        step("misalign",     1'b0, 1'b0, 1'b1, 32'h42,       32'h40,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b1);
        step("misalign_end", 1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       INSTR, 1'b1, 1'b0, 1'b0);
`else
        step("misalign",     1'b0, 1'b0, 1'b1, 32'h42,       32'h42,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("misalign_end", 1'b0, 1'b0, 1'b0, 32'h0,        32'h46,       32'h42,       32'h46,       INSTR, 1'b1, 1'b0, 1'b0);
`endif
        step("aligned_redir",1'b0, 1'b0, 1'b1, 32'h60,       32'h60,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stall.
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        compare("reset_mid_stall", rst_view);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        step("boot_redirect",1'b0, 1'b0, 1'b1, 32'h80,       32'h80,       32'h0,        32'h0,        NOP,   1'b0, 1'b0, 1'b0);
        step("boot_then_run",1'b0, 1'b0, 1'b0, 32'h0,        32'h84,       32'h80,       32'h84,       INSTR, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
